// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - command/status bundle between a requester and the shift sequencer
//
// Purpose: groups the command inputs (start, mode, pin, nshift, sin) and the
// status outputs (busy, done, pout, sout) of shift_seq_ctrl.
// Modports:
//   master - requester side: drives start/mode/pin/nshift/sin, observes busy/done/pout/sout
//   slave  - sequencer side: the reverse directions
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] pin;
    logic [CNT_W-1:0] nshift;
    logic             sin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] pout;
    logic             sout;

    modport master (
        output start, mode, pin, nshift, sin,
        input  busy, done, pout, sout
    );

    modport slave (
        input  start, mode, pin, nshift, sin,
        output busy, done, pout, sout
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - sequencer running N single-bit shift/rotate steps on a WIDTH-bit register
//
// Purpose: accepts a command (parallel word, step count, mode) while idle, then
// performs one shift or rotate step per clock until the count is exhausted, and
// pulses done for one cycle.
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst      - synchronous active-high reset, overrides everything (aborts a run, no done)
//   bus      - shift_seq_ctrl_if.slave:
//                start  command strobe, only looked at in IDLE
//                mode   00 shl, 01 shr, 10 rotl, 11 rotr (latched at start)
//                pin    parallel load word (latched at start)
//                nshift number of steps (latched at start), 0 goes straight to DONE
//                sin    fill bit for shift modes, sampled on every SHIFT edge
//                busy   high while stepping
//                done   one-cycle completion pulse
//                pout   current register contents
//                sout   bit at the exiting end of the register for the latched mode
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_seq_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] M_SHL  = 2'b00;
    localparam logic [1:0] M_SHR  = 2'b01;
    localparam logic [1:0] M_ROTL = 2'b10;
    localparam logic [1:0] M_ROTR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] stepped;

    // One step of the latched operation applied to the current register.
    always_comb begin
        stepped = reg_q;
        case (mode_q)
            M_SHL:   stepped = {reg_q[WIDTH-2:0], bus.sin};
            M_SHR:   stepped = {bus.sin, reg_q[WIDTH-1:1]};
            M_ROTL:  stepped = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
            M_ROTR:  stepped = {reg_q[0], reg_q[WIDTH-1:1]};
            default: stepped = reg_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    reg_d   = bus.pin;
                    cnt_d   = bus.nshift;
                    mode_d  = bus.mode;
                    state_d = (bus.nshift == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                reg_d = stepped;
                cnt_d = cnt_q - CNT_W'(1);
                // cnt==1 means this edge performs the final step.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= M_SHL;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Status decodes straight from state so busy and done can never overlap.
    assign bus.busy = (state_q == S_SHIFT);
    assign bus.done = (state_q == S_DONE);
    assign bus.pout = reg_q;
    // mode_q[0] selects right-going modes, whose exiting bit is the LSB.
    assign bus.sout = mode_q[0] ? reg_q[0] : reg_q[WIDTH-1];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl against a closed-form model
module tb_shift_seq_ctrl;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Register value after k steps. Shifts: view the register as a window on the
    // stream of pin followed by the fill bits; rotates: rotate by k mod W.
    function automatic logic [31:0] model_reg(input int p, input int m, input int k, input logic [15:0] sb);
        logic [31:0] acc;
        logic [31:0] lowk;
        int r;
        acc  = 0;
        lowk = 32'(sb) & ((32'd1 << k) - 1);
        r    = k % W;
        case (m)
            0: begin
                for (int j = 1; j <= k; j++) acc = acc | (32'(sb[j-1]) << (k - j));
                acc = ((32'(p) << k) | acc) & 32'hFF;
            end
            1: acc = (((lowk << 8) | 32'(p)) >> k) & 32'hFF;
            2: acc = ((32'(p) << r) | (32'(p) >> (W - r))) & 32'hFF;
            default: acc = ((32'(p) >> r) | (32'(p) << (W - r))) & 32'hFF;
        endcase
        return acc;
    endfunction

    // Bit leaving the register on step i (1-based).
    function automatic logic model_exit(input int p, input int m, input int i, input logic [15:0] sb);
        logic [7:0] pv;
        pv = p[7:0];
        case (m)
            0: return (i <= W) ? pv[W - i] : sb[i - W - 1];
            1: return (i <= W) ? pv[i - 1] : sb[i - W - 1];
            2: return pv[W - 1 - ((i - 1) % W)];
            default: return pv[(i - 1) % W];
        endcase
    endfunction

    task automatic drive_noise();
        bus.pin    = 8'($urandom);
        bus.mode   = 2'($urandom);
        bus.nshift = 4'($urandom);
    endtask

    // Entered and left at a negedge of an IDLE cycle.
    task automatic run_cmd(input logic [7:0] p, input logic [1:0] m, input int n,
                           input logic [15:0] sb, input bit noise);
        logic [31:0] fin;
        bus.start  = 1'b1;
        bus.pin    = p;
        bus.mode   = m;
        bus.nshift = 4'(n);
        bus.sin    = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= n; i++) begin
            check_val($sformatf("m%0d n%0d s%0d busy", m, n, i), 32'(bus.busy), 32'd1);
            check_val($sformatf("m%0d n%0d s%0d done", m, n, i), 32'(bus.done), 32'd0);
            check_val($sformatf("m%0d n%0d s%0d pout", m, n, i), 32'(bus.pout),
                      model_reg(int'(p), int'(m), i - 1, sb));
            check_val($sformatf("m%0d n%0d s%0d sout", m, n, i), 32'(bus.sout),
                      32'(model_exit(int'(p), int'(m), i, sb)));
            bus.sin = sb[i-1];
            if (noise) begin
                bus.start = 1'($urandom);
                drive_noise();
            end
            @(posedge clk);
            @(negedge clk);
        end
        fin = model_reg(int'(p), int'(m), n, sb);
        check_val($sformatf("m%0d n%0d done", m, n), 32'(bus.done), 32'd1);
        check_val($sformatf("m%0d n%0d busy@done", m, n), 32'(bus.busy), 32'd0);
        check_val($sformatf("m%0d n%0d result", m, n), 32'(bus.pout), fin);
        check_val($sformatf("m%0d n%0d sout@done", m, n), 32'(bus.sout),
                  32'(m[0] ? fin[0] : fin[7]));
        // start during DONE must be ignored.
        bus.start = noise;
        if (noise) drive_noise();
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check_val($sformatf("m%0d n%0d done_pulse", m, n), 32'(bus.done), 32'd0);
        check_val($sformatf("m%0d n%0d busy@idle", m, n), 32'(bus.busy), 32'd0);
        check_val($sformatf("m%0d n%0d hold", m, n), 32'(bus.pout), fin);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, ".pout"}, 32'(bus.pout), 32'd0);
        check_val({tag, ".sout"}, 32'(bus.sout), 32'd0);
        check_val({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check_val({tag, ".done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.mode   = 2'($urandom);
        bus.pin    = 8'($urandom);
        bus.nshift = 4'($urandom);
        bus.sin    = 1'($urandom);
        rst        = 1'b1;
        @(posedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst       = 1'b0;
        bus.start = 1'b0;

        run_cmd(8'hA5, 2'b00, 3, 16'hFFFF, 1'b0);
        run_cmd(8'h81, 2'b11, 8, 16'($urandom), 1'b0);
        run_cmd(8'h3C, 2'($urandom), 0, 16'($urandom), 1'b0);
        run_cmd(8'hFF, 2'b01, 5, 16'h0000, 1'b1);
        run_cmd(8'hFF, 2'b00, 15, 16'h0000, 1'b0);
        run_cmd(8'h5A, 2'b10, 15, 16'($urandom), 1'b1);

        // Abort mid-run: shift right of 0xFF, reset after two steps.
        bus.start  = 1'b1;
        bus.pin    = 8'hFF;
        bus.mode   = 2'b01;
        bus.nshift = 4'd5;
        bus.sin    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("abort.pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("abort");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("abort.no_done%0d", i), 32'(bus.done), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end

        // Random commands with occasional idle gaps.
        for (int t = 0; t < 40; t++) begin
            run_cmd(8'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 15),
                    16'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                @(negedge clk);
                check_val("gap.done", 32'(bus.done), 32'd0);
            end
        end

        // Reset in the middle of random activity, held for two edges.
        bus.start  = 1'b1;
        bus.pin    = 8'($urandom);
        bus.mode   = 2'($urandom);
        bus.nshift = 4'($urandom_range(4, 15));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("midreset");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("midreset.after_done", 32'(bus.done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
